dp_arbiter: RTL and testbench
=============================

DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requester FSMs sharing one datapath.
REQ-002 SHALL have parameter ID_WIDTH, default 2, width of grant index, ceil(log2(NUM_REQ)) minimum 1.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start_req  input  NUM_REQ  per-requester start level, held for at least 1 cycle, bit i = requester i.
REQ-006 SHALL have port instruction_req  input  NUM_REQ*INSTRUCTION_WIDTH  packed instructions, slice i = requester i.
REQ-007 SHALL have port finished_req  output  NUM_REQ  per-requester completion level; 1 = idle or result valid.
REQ-008 SHALL have port result_req  output  NUM_REQ*RESULT_WIDTH  per-requester result, held until that requester's next accepted op.
REQ-009 SHALL have port start_dp  output  1  start to the shared datapath.
REQ-010 SHALL have port instruction_dp  output  INSTRUCTION_WIDTH  instruction to the datapath.
REQ-011 SHALL have port finished_dp  input  1  datapath completion level.
REQ-012 SHALL have port result_dp  input  RESULT_WIDTH  datapath result, valid when finished_dp=1 in WAIT.
REQ-013 SHALL have port busy  output  1  1 whenever the state is not IDLE.
REQ-014 SHALL have port grant_id  output  ID_WIDTH  index of the requester currently or last served.

Function
REQ-015 Accept: on an edge sampling start_req[i]=1 and finished_req[i]=1, SHALL latch instruction slice i into pend_instr[i], set pending[i]=1 and clear finished_req[i] on that edge.
REQ-016 Start_req[i] sampled while finished_req[i]=0 SHALL be ignored; no instruction relatch.
REQ-017 Requester sees finished_req[i]=0 no later than 1 cycle after its first start cycle, so a 2-cycle START/DELAY requester never reads a stale 1 in WAIT.
REQ-018 FSM states SHALL be IDLE, ISSUE, HOLD, WAIT, DONE.
REQ-019 IDLE: if any pending bit set, SHALL pick winner by round-robin, set grant_id, load instruction_dp from pend_instr[winner], go ISSUE; else stay.
REQ-020 Round-robin SHALL search from (last grant_id+1) mod NUM_REQ upward with wrap; after reset search starts at 0.
REQ-021 ISSUE and HOLD SHALL drive start_dp=1 for exactly 2 cycles; WAIT and all other states SHALL drive start_dp=0.
REQ-022 instruction_dp SHALL stay constant from ISSUE until leaving WAIT.
REQ-023 WAIT: on finished_dp=1 SHALL capture result_dp into result slice grant_id, go DONE; else stay indefinitely.
REQ-024 DONE: SHALL set finished_req[grant_id]=1, clear pending[grant_id], go IDLE; one cycle.
REQ-025 Minimum per-op latency, accept edge to finished_req rising: 5 cycles plus datapath WAIT time.
REQ-026 New accepts for non-granted requesters SHALL be processed in every state, including the DONE cycle.
REQ-027 Single requester back-to-back: start asserted the cycle after finished_req rises SHALL be accepted normally.
REQ-028 No requester SHALL wait more than NUM_REQ-1 other grants after becoming pending.
REQ-029 result_req slices of non-granted requesters SHALL never change.

Reset
REQ-030 On resetn=0: state=IDLE, start_dp=0, instruction_dp=0, finished_req all 1, result_req all 0, pending all 0, pend_instr all 0, grant_id=0, busy=0.
REQ-031 Reset mid-operation SHALL abandon the in-flight op with no result written; datapath shares the same resetn.

Structure
REQ-032 INSTRUCTION_WIDTH, RESULT_WIDTH and new DP_ARB_OP_WIDTH and state codes SHALL live in the shared constants.h header.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_pick (inputs pending, last id; outputs winner id, any).

Verification
REQ-034 Reset then idle -> finished_req=3'b111, start_dp=0, busy=0 for 10 cycles.
REQ-035 Req0 instr 0x0A, datapath finishes 3 cycles after WAIT entry with result 0x55 -> start_dp high exactly 2 cycles, result_req slice0=0x55, finished_req[0] rises 8 cycles after accept.
REQ-036 Req0,1,2 start same cycle, instrs 0x1,0x2,0x3 -> dispatch order 0,1,2; each result only in own slice.
REQ-037 Req1 continuously re-requesting while req2 pending -> grants alternate 1,2,1,2.
REQ-038 Req0 re-asserts start while its op is in WAIT -> ignored, one datapath op only, instruction_dp unchanged.
REQ-039 resetn low during WAIT with req1 pending -> all outputs at reset values next cycle; no result_req change.

Source files
------------

// File: rtl/dp_arbiter_pkg.sv
// Shared constants for the datapath arbiter: operand widths and FSM state codes.
package dp_arbiter_pkg;

    localparam int INSTRUCTION_WIDTH = 8;
    localparam int RESULT_WIDTH      = 8;
    localparam int DP_ARB_OP_WIDTH   = 3;

    typedef enum logic [DP_ARB_OP_WIDTH-1:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/dp_arbiter_rr_pick.sv
// Round-robin winner search: scans pending bits starting one past last_id, wrapping.
module rr_pick #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  pending,
    input  logic [ID_WIDTH-1:0] last_id,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any
);

    int idx;

    // First set pending bit at or after last_id+1 (mod NUM_REQ) wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last_id) + 1 + k) % NUM_REQ;
            if (!any && pending[ID_WIDTH'(idx)]) begin
                winner = ID_WIDTH'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_arbiter.sv
// Shares one start/finished datapath between NUM_REQ requester FSMs.
// Each requester sees its own start/instruction/finished/result handshake;
// accepted requests are queued as pending bits and served round-robin.
// Handshake: a request is accepted on an edge where start_req[i]=1 and
// finished_req[i]=1; finished_req[i] then stays 0 until the result slice is
// valid. Toward the datapath, start_dp is held 2 cycles and the result is
// taken on the first WAIT cycle that samples finished_dp=1.
module dp_arbiter
    import dp_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic [NUM_REQ-1:0]                   start_req,
    input  logic [NUM_REQ*INSTRUCTION_WIDTH-1:0] instruction_req,
    output logic [NUM_REQ-1:0]                   finished_req,
    output logic [NUM_REQ*RESULT_WIDTH-1:0]      result_req,
    output logic                                 start_dp,
    output logic [INSTRUCTION_WIDTH-1:0]         instruction_dp,
    input  logic                                 finished_dp,
    input  logic [RESULT_WIDTH-1:0]              result_dp,
    output logic                                 busy,
    output logic [ID_WIDTH-1:0]                  grant_id,
    output logic [DP_ARB_OP_WIDTH-1:0]           dbg_state
);

    arb_state_t                   state;
    logic [NUM_REQ-1:0]           pending;
    logic [INSTRUCTION_WIDTH-1:0] pend_instr [NUM_REQ];
    // Search origin kept apart from grant_id so that after reset the
    // search begins at requester 0 while grant_id still reads 0.
    logic [ID_WIDTH-1:0]          rr_last;
    logic [ID_WIDTH-1:0]          pick_id;
    logic                         pick_any;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .pending (pending),
        .last_id (rr_last),
        .winner  (pick_id),
        .any     (pick_any)
    );

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Request acceptance for every requester plus the single serving FSM.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            start_dp       <= 1'b0;
            instruction_dp <= '0;
            finished_req   <= '1;
            result_req     <= '0;
            pending        <= '0;
            grant_id       <= '0;
            rr_last        <= ID_WIDTH'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_instr[i] <= '0;
            end
        end else begin
            // Accepts run in every state; a busy requester (finished=0) is ignored.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (start_req[i] && finished_req[i]) begin
                    pend_instr[i]   <= instruction_req[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
                    pending[i]      <= 1'b1;
                    finished_req[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id       <= pick_id;
                        rr_last        <= pick_id;
                        instruction_dp <= pend_instr[pick_id];
                        start_dp       <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    start_dp <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (finished_dp) begin
                        result_req[int'(grant_id)*RESULT_WIDTH +: RESULT_WIDTH] <= result_dp;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    finished_req[grant_id] <= 1'b1;
                    pending[grant_id]      <= 1'b0;
                    state                  <= ST_IDLE;
                end
                default: begin
                    start_dp <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: a behavioural datapath, a timestamp-based reference
// model of the requester-visible behaviour, directed scenarios and random traffic.
module tb_dp_arbiter;
    import dp_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int IW  = INSTRUCTION_WIDTH;
    localparam int RW  = RESULT_WIDTH;

    logic              clock;
    logic              resetn;
    logic [N-1:0]      start_req;
    logic [N*IW-1:0]   instruction_req;
    logic [N-1:0]      finished_req;
    logic [N*RW-1:0]   result_req;
    logic              start_dp;
    logic [IW-1:0]     instruction_dp;
    logic              finished_dp;
    logic [RW-1:0]     result_dp;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic [DP_ARB_OP_WIDTH-1:0] dbg_state;

    dp_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .start_req       (start_req),
        .instruction_req (instruction_req),
        .finished_req    (finished_req),
        .result_req      (result_req),
        .start_dp        (start_dp),
        .instruction_dp  (instruction_dp),
        .finished_dp     (finished_dp),
        .result_dp       (result_dp),
        .busy            (busy),
        .grant_id        (grant_id),
        .dbg_state       (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural datapath: after start falls, counts dp_delay cycles, then
    // raises finished with result = instruction ^ 0x5F.
    int dp_delay = 3;
    int dp_cnt;
    bit dp_run;
    always @(posedge clock) begin
        if (!resetn) begin
            finished_dp <= 1'b1;
            result_dp   <= '0;
            dp_cnt      <= 0;
            dp_run      <= 1'b0;
        end else if (start_dp) begin
            finished_dp <= 1'b0;
            dp_run      <= 1'b1;
            dp_cnt      <= 0;
        end else if (dp_run) begin
            dp_cnt <= dp_cnt + 1;
            if (dp_cnt + 1 >= dp_delay) begin
                finished_dp <= 1'b1;
                result_dp   <= instruction_dp ^ 8'h5F;
                dp_run      <= 1'b0;
            end
        end
    end

    // Scoreboard bookkeeping
    int errors = 0;
    int checks = 0;
    logic [IDW-1:0] exp_q[$];
    int  rises = 0;
    logic prev_sdp = 1'b0;

    // Reference model: per-requester flags plus timestamps of the op in flight.
    logic [N-1:0]  m_fin;
    logic [N-1:0]  m_pend;
    logic [IW-1:0] m_instr [N];
    logic [RW-1:0] m_res   [N];
    bit            m_active;
    int            t_disp, t_res;
    int            m_gid, m_next;
    logic [IW-1:0] m_idp;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_fin    = '1;
        m_pend   = '0;
        m_active = 1'b0;
        m_gid    = 0;
        m_next   = 0;
        m_idp    = '0;
        t_disp   = 0;
        t_res    = -1;
        for (int i = 0; i < N; i++) begin
            m_instr[i] = '0;
            m_res[i]   = '0;
        end
    endfunction

    function automatic logic [N*RW-1:0] m_res_packed();
        logic [N*RW-1:0] v;
        for (int i = 0; i < N; i++) v[i*RW +: RW] = m_res[i];
        return v;
    endfunction

    // One clock: snapshot inputs, advance DUT and model, compare all outputs.
    task automatic tick();
        logic [N-1:0]    s_start, pre_pend, pre_fin;
        logic [N*IW-1:0] s_instr;
        logic            s_fdp, s_rst;
        logic [RW-1:0]   s_rdp;
        bit              found;
        int              idx;
        s_start = start_req;
        s_instr = instruction_req;
        s_fdp   = finished_dp;
        s_rdp   = result_dp;
        s_rst   = resetn;
        @(posedge clock);
        #1;
        cyc++;
        if (!s_rst) begin
            m_reset();
        end else begin
            pre_pend = m_pend;
            pre_fin  = m_fin;
            if (!m_active) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_next + k) % N;
                    if (!found && pre_pend[idx]) begin
                        found    = 1'b1;
                        m_gid    = idx;
                        m_next   = (idx + 1) % N;
                        m_active = 1'b1;
                        t_disp   = cyc;
                        t_res    = -1;
                        m_idp    = m_instr[idx];
                    end
                end
            end else if (t_res < 0) begin
                if (cyc >= t_disp + 3 && s_fdp) begin
                    t_res        = cyc;
                    m_res[m_gid] = s_rdp;
                end
            end else begin
                m_fin[m_gid]  = 1'b1;
                m_pend[m_gid] = 1'b0;
                m_active      = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (s_start[i] && pre_fin[i]) begin
                    m_pend[i]  = 1'b1;
                    m_fin[i]   = 1'b0;
                    m_instr[i] = s_instr[i*IW +: IW];
                end
            end
        end
        chk("finished_req", 32'(finished_req), 32'(m_fin));
        chk("result_req", 32'(result_req), 32'(m_res_packed()));
        chk("start_dp", 32'(start_dp), 32'(m_active && (cyc - t_disp) < 2));
        chk("busy", 32'(busy), 32'(m_active));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("instruction_dp", 32'(instruction_dp), 32'(m_idp));
        if (start_dp && !prev_sdp) begin
            rises++;
            if (exp_q.size() > 0) chk("dispatch_order", 32'(grant_id), 32'(exp_q.pop_front()));
        end
        prev_sdp = start_dp;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        start_req = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin : stim
        int acc, lat, hi, n;
        resetn          = 1'b0;
        start_req       = '0;
        instruction_req = '0;
        m_reset();

        // Reset then idle for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("idle_finished", 32'(finished_req), 32'h7);

        // Single op on requester 0: latency, start width, result.
        dp_delay = 3;
        instruction_req = {8'h00, 8'h00, 8'h0A};
        start_req = 3'b001;
        tick();
        acc = cyc;
        start_req = '0;
        hi = 0;
        n = 0;
        while (!finished_req[0] && n < 50) begin
            tick();
            if (start_dp) hi++;
            n++;
        end
        chk("single_latency", 32'(cyc - acc), 32'd8);
        chk("single_start_cycles", 32'(hi), 32'd2);
        chk("single_result", 32'(result_req[RW-1:0]), 32'h55);
        tick();

        // Three simultaneous requests: dispatch 0,1,2.
        do_reset();
        dp_delay = 2;
        rises = 0;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        instruction_req = {8'h03, 8'h02, 8'h01};
        start_req = 3'b111;
        tick();
        start_req = '0;
        n = 0;
        while (finished_req != 3'b111 && n < 100) begin tick(); n++; end
        chk("three_done", 32'(finished_req), 32'h7);
        chk("three_order_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < N; i++) begin
            logic [RW-1:0] want;
            want = 8'(i + 1) ^ 8'h5F;
            chk("three_result_slice", 32'(result_req[i*RW +: RW]), 32'(want));
        end

        // Requesters 1 and 2 re-requesting continuously: grants alternate.
        do_reset();
        dp_delay = 1;
        exp_q.delete();
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        instruction_req = {8'h22, 8'h11, 8'h00};
        start_req = 3'b110;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
        chk("alternate_grants_left", 32'(exp_q.size()), 32'd0);
        start_req = '0;
        for (int i = 0; i < 30; i++) tick();

        // Re-asserted start during WAIT is ignored.
        do_reset();
        dp_delay = 4;
        rises = 0;
        instruction_req = {8'h00, 8'h00, 8'h0A};
        start_req = 3'b001;
        tick();
        start_req = '0;
        for (int i = 0; i < 4; i++) tick();
        instruction_req = {8'h00, 8'h00, 8'h77};
        start_req = 3'b001;
        tick();
        tick();
        start_req = '0;
        for (int i = 0; i < 20; i++) tick();
        chk("wait_restart_ops", 32'(rises), 32'd1);
        chk("wait_restart_result", 32'(result_req[RW-1:0]), 32'h55);

        // Reset during WAIT with requester 1 pending.
        do_reset();
        dp_delay = 8;
        instruction_req = {8'h00, 8'h44, 8'h33};
        start_req = 3'b001;
        tick();
        start_req = 3'b010;
        tick();
        start_req = '0;
        for (int i = 0; i < 4; i++) tick();
        resetn = 1'b0;
        tick();
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_finished", 32'(finished_req), 32'h7);
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("postreset_result", 32'(result_req), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            start_req       = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            instruction_req = N*IW'($urandom);
            dp_delay        = $urandom_range(1, 5);
            resetn          = ($urandom_range(0, 199) != 0);
            tick();
        end
        resetn    = 1'b1;
        start_req = '0;
        for (int i = 0; i < 40; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
